// File: rtl/sseg_pkg.sv
// Shared types and constants for the 7-segment scan controller slice.
// Glyph codes match the downstream decoder's code table.
package sseg_pkg;

    localparam int GLYPH_W = 5;

    localparam logic [GLYPH_W-1:0] G_H     = 5'd10;
    localparam logic [GLYPH_W-1:0] G_E     = 5'd11;
    localparam logic [GLYPH_W-1:0] G_L     = 5'd12;
    localparam logic [GLYPH_W-1:0] G_P     = 5'd13;
    localparam logic [GLYPH_W-1:0] G_A     = 5'd14;
    localparam logic [GLYPH_W-1:0] G_C     = 5'd15;
    localparam logic [GLYPH_W-1:0] G_F     = 5'd16;
    localparam logic [GLYPH_W-1:0] G_U     = 5'd17;
    localparam logic [GLYPH_W-1:0] G_N     = 5'd18;
    localparam logic [GLYPH_W-1:0] G_R     = 5'd19;
    localparam logic [GLYPH_W-1:0] G_T     = 5'd20;
    localparam logic [GLYPH_W-1:0] G_X     = 5'd21;
    localparam logic [GLYPH_W-1:0] G_BLANK = 5'd31;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    // Counter width for values 0..v-1, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Host-side frame handshake and live blink mask of the scan controller.
interface sseg_scan_ctrl_if #(
    parameter int NDIG = 4
);
    import sseg_pkg::*;

    logic [NDIG*GLYPH_W-1:0] frame_in;
    logic                    frame_valid;
    logic                    frame_ready;
    logic [NDIG-1:0]         blink_mask;

    modport master (
        output frame_in,
        output frame_valid,
        output blink_mask,
        input  frame_ready
    );

    modport slave (
        input  frame_in,
        input  frame_valid,
        input  blink_mask,
        output frame_ready
    );

endinterface

// File: rtl/sseg_frame_buf.sv
// Pending/active double buffer: host frames land in pending and move to
// active only at a frame boundary, so a scan never mixes two frames.
module sseg_frame_buf
    import sseg_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NDIG*GLYPH_W-1:0] frame_in,
    input  logic                    frame_valid,
    output logic                    frame_ready,
    input  logic                    promote,
    output logic [NDIG*GLYPH_W-1:0] active
);

    logic [NDIG*GLYPH_W-1:0] pending_r;
    logic [NDIG*GLYPH_W-1:0] active_r;
    logic                    full_r;
    logic                    ready_r;
    logic                    accept_s;

    assign accept_s    = frame_valid && ready_r;
    assign frame_ready = ready_r;
    assign active      = active_r;

    // Promotion and acceptance are exclusive: accept needs pending empty, promote needs it full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= '0;
            active_r  <= '0;
            full_r    <= 1'b0;
            ready_r   <= 1'b1;
        end else if (promote && full_r) begin
            active_r <= pending_r;
            full_r   <= 1'b0;
            ready_r  <= 1'b1;
        end else if (accept_s) begin
            pending_r <= frame_in;
            full_r    <= 1'b1;
            ready_r   <= 1'b0;
        end
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed scan of a common-anode 7-segment bank: guard blanking
// before each digit slot, per-digit blink, tear-free frame swap.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int NDIG         = 4,
    parameter int DIG_CYCLES   = 50000,
    parameter int GUARD        = 500,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                clk,
    input  logic                rst,
    sseg_scan_ctrl_if.slave     host,
    output logic [NDIG-1:0]     an,
    output logic [GLYPH_W-1:0]  code,
    output logic                frame_done
);

    localparam int CNT_MAX = (DIG_CYCLES > GUARD) ? DIG_CYCLES : GUARD;
    localparam int CNT_W   = clog2_min1(CNT_MAX);
    localparam int IDX_W   = clog2_min1(NDIG);
    localparam int FCNT_W  = clog2_min1(BLINK_FRAMES);

    localparam logic [CNT_W-1:0]  GUARD_LAST = CNT_W'(GUARD - 1);
    localparam logic [CNT_W-1:0]  DIG_LAST   = CNT_W'(DIG_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NDIG - 1);
    localparam logic [FCNT_W-1:0] FRAME_LAST = FCNT_W'(BLINK_FRAMES - 1);

    scan_state_t             state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [IDX_W-1:0]        idx_r;
    logic [FCNT_W-1:0]       fcnt_r;
    logic                    blink_off_r;
    logic [NDIG-1:0]         an_r;
    logic [GLYPH_W-1:0]      code_r;
    logic                    done_r;

    logic                    boundary_s;
    logic [IDX_W-1:0]        next_idx_s;
    logic [NDIG-1:0]         drive_an_s;
    logic [GLYPH_W-1:0]      sel_code_s;
    logic [NDIG*GLYPH_W-1:0] active_s;

    sseg_frame_buf #(.NDIG(NDIG)) u_frame_buf (
        .clk         (clk),
        .rst         (rst),
        .frame_in    (host.frame_in),
        .frame_valid (host.frame_valid),
        .frame_ready (host.frame_ready),
        .promote     (boundary_s),
        .active      (active_s)
    );

    // Slot decode: boundary, next digit, anode pattern (blink-gated) and glyph for idx_r.
    always_comb begin
        boundary_s = (state_r == DRIVE) && (cnt_r == DIG_LAST) && (idx_r == IDX_LAST);
        if (idx_r == IDX_LAST) begin
            next_idx_s = '0;
        end else begin
            next_idx_s = idx_r + IDX_W'(1);
        end
        drive_an_s = '1;
        sel_code_s = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_r == IDX_W'(i)) begin
                drive_an_s[i] = blink_off_r && host.blink_mask[i];
                sel_code_s    = active_s[i*GLYPH_W +: GLYPH_W];
            end else begin
                drive_an_s[i] = 1'b1;
            end
        end
    end

    // Scan FSM with registered anode/code/frame_done, plus blink phase tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= BLANK;
            cnt_r       <= '0;
            idx_r       <= '0;
            fcnt_r      <= '0;
            blink_off_r <= 1'b0;
            an_r        <= '1;
            code_r      <= '0;
            done_r      <= 1'b0;
        end else begin
            done_r <= boundary_s;
            case (state_r)
                BLANK: begin
                    if (cnt_r == GUARD_LAST) begin
                        state_r <= DRIVE;
                        cnt_r   <= '0;
                        an_r    <= drive_an_s;
                        code_r  <= sel_code_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        an_r  <= '1;
                    end
                end
                DRIVE: begin
                    if (cnt_r == DIG_LAST) begin
                        state_r <= BLANK;
                        cnt_r   <= '0;
                        idx_r   <= next_idx_s;
                        an_r    <= '1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        an_r  <= drive_an_s;
                    end
                end
                default: begin
                    state_r <= BLANK;
                    cnt_r   <= '0;
                    an_r    <= '1;
                end
            endcase
            if (boundary_s) begin
                if (fcnt_r == FRAME_LAST) begin
                    fcnt_r      <= '0;
                    blink_off_r <= ~blink_off_r;
                end else begin
                    fcnt_r <= fcnt_r + FCNT_W'(1);
                end
            end
        end
    end

    assign an         = an_r;
    assign code       = code_r;
    assign frame_done = done_r;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Scoreboard bench: stimulus queues the expected anode/code of each digit slot,
// a monitor pops and compares mid-slot; guard blanking and frame_done are checked by cycle position.
module tb_sseg_scan_ctrl;
    import sseg_pkg::*;

    localparam int NDIG = 4;

    typedef struct packed {
        logic [3:0] an;
        logic [4:0] code;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] an;
    logic [4:0] code;
    logic       frame_done;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   t        = 0;
    bit   mon_en   = 1'b0;

    sseg_scan_ctrl_if #(.NDIG(NDIG)) bus ();

    sseg_scan_ctrl #(
        .NDIG(NDIG), .DIG_CYCLES(4), .GUARD(1), .BLINK_FRAMES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .host       (bus.slave),
        .an         (an),
        .code       (code),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d actual=%0h expected=%0h", name, t, act, exp);
        end
    endtask

    // Slot k of each frame is driven for cycles 5k+1..5k+4; sampled at 5k+2.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                t++;
                chk("frame_done", 32'(frame_done), 32'((t % 20) == 0));
                if ((t % 5) == 0) chk("guard_an", 32'(an), 32'h0000000F);
                if ((t % 5) == 2 && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("slot_an", 32'(an), 32'(e.an));
                    chk("slot_code", 32'(code), 32'(e.code));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog t=%0d actual=running expected=finished", t);
        $fatal(1, "watchdog expired");
    end

    task automatic push_frame(input logic [19:0] f, input logic [3:0] off);
        exp_t e;
        for (int k = 0; k < NDIG; k++) begin
            e.an   = off[k] ? 4'hF : ~(4'b0001 << k);
            e.code = f[5*k +: 5];
            exp_q.push_back(e);
        end
    endtask

    task automatic at_cycle(input int n);
        wait (t == n);
        @(negedge clk);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        exp_q.delete();
        bus.frame_valid = 1'b0;
        bus.frame_in    = 20'd0;
        bus.blink_mask  = 4'b0000;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_an", 32'(an), 32'h0000000F);
        chk("rst_code", 32'(code), 32'd0);
        chk("rst_ready", 32'(bus.frame_ready), 32'd1);
        chk("rst_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        t      = 0;
        mon_en = 1'b1;
    endtask

    task automatic end_test(input int n);
        at_cycle(n);
        chk("slots_left", 32'(exp_q.size()), 32'd0);
    endtask

    localparam logic [19:0] ZERO = 20'd0;
    localparam logic [19:0] F2   = {5'd21, 5'd12, 5'd1, 5'd0};
    localparam logic [19:0] FA   = {5'd4, 5'd3, 5'd2, 5'd1};
    localparam logic [19:0] FB   = {5'd30, 5'd22, 5'd9, 5'd8};
    localparam logic [19:0] FC   = {5'd13, 5'd10, 5'd7, 5'd6};
    localparam logic [19:0] FD   = {5'd5, 5'd6, 5'd7, 5'd8};

    initial begin : stimulus
        int w;

        // Idle scan with the reset frame of zeros.
        do_reset();
        push_frame(ZERO, 4'b0000);
        push_frame(ZERO, 4'b0000);
        end_test(41);

        // Single frame: held in pending until the first boundary.
        do_reset();
        push_frame(ZERO, 4'b0000);
        push_frame(F2, 4'b0000);
        at_cycle(3);
        chk("t2_ready_c3", 32'(bus.frame_ready), 32'd1);
        bus.frame_in = F2;
        bus.frame_valid = 1'b1;
        at_cycle(4);
        bus.frame_valid = 1'b0;
        chk("t2_ready_c4", 32'(bus.frame_ready), 32'd0);
        at_cycle(19);
        chk("t2_ready_c19", 32'(bus.frame_ready), 32'd0);
        at_cycle(20);
        chk("t2_ready_c20", 32'(bus.frame_ready), 32'd1);
        end_test(41);

        // Back-to-back A then B: B stalls until A is promoted.
        do_reset();
        push_frame(ZERO, 4'b0000);
        push_frame(FA, 4'b0000);
        push_frame(FB, 4'b0000);
        at_cycle(2);
        bus.frame_in = FA;
        bus.frame_valid = 1'b1;
        at_cycle(3);
        bus.frame_in = FB;
        chk("t3_ready_c3", 32'(bus.frame_ready), 32'd0);
        w = 0;
        while (!bus.frame_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("t3_b_ready", 32'(bus.frame_ready), 32'd1);
        chk("t3_b_accept_cycle", 32'(t), 32'd20);
        @(negedge clk);
        bus.frame_valid = 1'b0;
        chk("t3_ready_c21", 32'(bus.frame_ready), 32'd0);
        end_test(61);

        // Accept on the boundary edge: shown one frame later.
        do_reset();
        push_frame(ZERO, 4'b0000);
        push_frame(ZERO, 4'b0000);
        push_frame(FC, 4'b0000);
        at_cycle(19);
        chk("t4_ready_c19", 32'(bus.frame_ready), 32'd1);
        bus.frame_in = FC;
        bus.frame_valid = 1'b1;
        at_cycle(20);
        bus.frame_valid = 1'b0;
        chk("t4_ready_c20", 32'(bus.frame_ready), 32'd0);
        at_cycle(39);
        chk("t4_ready_c39", 32'(bus.frame_ready), 32'd0);
        at_cycle(40);
        chk("t4_ready_c40", 32'(bus.frame_ready), 32'd1);
        end_test(61);

        // Blink digit 1: off in frames 2-3 and 6-7.
        do_reset();
        bus.blink_mask = 4'b0010;
        for (int f = 0; f < 8; f++) begin
            push_frame(ZERO, (f % 4 >= 2) ? 4'b0010 : 4'b0000);
        end
        end_test(161);

        // Reset mid-DRIVE of digit 2 with a frame pending.
        do_reset();
        push_frame(ZERO, 4'b0000);
        at_cycle(2);
        bus.frame_in = FD;
        bus.frame_valid = 1'b1;
        at_cycle(3);
        bus.frame_valid = 1'b0;
        chk("t6_ready_c3", 32'(bus.frame_ready), 32'd0);
        at_cycle(12);
        chk("t6_an_digit2", 32'(an), 32'h0000000B);
        mon_en = 1'b0;
        exp_q.delete();
        rst = 1'b1;
        #1;
        chk("t6_async_an", 32'(an), 32'h0000000F);
        chk("t6_async_code", 32'(code), 32'd0);
        chk("t6_async_ready", 32'(bus.frame_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        t = 0;
        push_frame(ZERO, 4'b0000);
        push_frame(ZERO, 4'b0000);
        mon_en = 1'b1;
        at_cycle(1);
        chk("t6_restart_an", 32'(an), 32'h0000000E);
        end_test(41);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
